// File: rtl/mm_writeback.sv
// mm_writeback: result write-back stage with optional per-lane ReLU and a result FIFO feeding the output buffer
// Ports:
//   clk, rstn                   rising-edge clock, asynchronous active-low reset
//   start_valid, relu_en,
//   expected_count              job start; latches ReLU enable and the number of result vectors
//   in_valid, in_addr, in_data  result vectors from the matrix unit (no back-pressure)
//   in_ready                    FIFO not full (advisory)
//   buf_wr_en, buf_wr_addr,
//   buf_wr_data, buf_wr_ready   output-buffer write port, head of FIFO
//   busy, overflow, done        job status: running/draining, sticky drop flag, completion pulse
module mm_writeback #(
    parameter int DEPTH = 4,
    parameter int LANES = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_valid,
    input  logic                  relu_en,
    input  logic [15:0]           expected_count,
    input  logic                  in_valid,
    input  logic [10:0]           in_addr,
    input  logic [LANES*32-1:0]   in_data,
    output logic                  in_ready,
    output logic                  buf_wr_en,
    output logic [10:0]           buf_wr_addr,
    output logic [LANES*32-1:0]   buf_wr_data,
    input  logic                  buf_wr_ready,
    output logic                  busy,
    output logic                  overflow,
    output logic                  done
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = LANES * 32;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [DW+10:0]  mem [DEPTH];
    logic [15:0]     acc_cnt, wr_cnt, exp_cnt;
    logic            relu_q, full, empty, pop, push, drop, start;
    logic [DW-1:0]   proc_data;

    // extra pointer bit tells full (MSBs differ) from empty (pointers equal)
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign pop   = !empty && buf_wr_ready;
    // a same-cycle pop frees the slot, so a full FIFO can still accept
    assign push  = (state == RUN) && in_valid && (!full || pop);
    assign drop  = (state == RUN) && in_valid && full && !pop;
    assign start = (state == IDLE) && start_valid;

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_relu
            assign proc_data[32*i +: 32] = (relu_q && in_data[32*i+31]) ? 32'd0 : in_data[32*i +: 32];
        end
    endgenerate

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_valid ? ((expected_count == 16'd0) ? DONE : RUN) : IDLE;
            RUN:     state_nx = (push && (acc_cnt + 16'd1 == exp_cnt)) ? DRAIN : RUN;
            DRAIN:   state_nx = (wr_cnt == exp_cnt) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            exp_cnt  <= '0;
            relu_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (start) begin
                acc_cnt  <= '0;
                wr_cnt   <= '0;
                overflow <= 1'b0;
                exp_cnt  <= expected_count;
                relu_q   <= relu_en;
            end else begin
                if (push)
                    acc_cnt <= acc_cnt + 16'd1;
                if (pop)
                    wr_cnt <= wr_cnt + 16'd1;
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

    // storage needs no reset: the head is masked to zero whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {in_addr, proc_data};
    end

    assign {buf_wr_addr, buf_wr_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign buf_wr_en = !empty;
    assign in_ready  = !full;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = state == DONE;
endmodule

// File: doc/mm_writeback.md
MM_WRITEBACK -- requirements
Module: mm_writeback

Interface
REQ-001 SHALL have parameter DEPTH, 4, result FIFO depth in 512-bit entries (power of 2, ≥2).
REQ-002 SHALL have parameter LANES, 16, number of 32-bit signed lanes per 512-bit vector.
REQ-003 SHALL use reset rstn, asynchronous, active-low, and clock clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rstn  in  1  async active-low reset.
REQ-006 start_valid  in  1  one-cycle job start; samples relu_en and expected_count.
REQ-007 relu_en  in  1  1 = apply per-lane ReLU to results.
REQ-008 expected_count  in  16  number of result vectors in this job.
REQ-009 in_valid  in  1  result vector present (driven from mm output_data_valid).
REQ-010 in_addr  in  11  output-buffer address of result.
REQ-011 in_data  in  512  result vector, lane i = bits [32i+31:32i].
REQ-012 in_ready  out  1  FIFO not full (advisory; upstream has no stall).
REQ-013 buf_wr_en  out  1  output-buffer write request.
REQ-014 buf_wr_addr  out  11  write address.
REQ-015 buf_wr_data  out  512  write data.
REQ-016 buf_wr_ready  in  1  output buffer accepts write this cycle.
REQ-017 busy  out  1  high in RUN and DRAIN.
REQ-018 overflow  out  1  sticky: a result was dropped.
REQ-019 done  out  1  one-cycle job-complete pulse.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE->RUN on start_valid with expected_count≠0; IDLE->DONE on start_valid with expected_count=0.
REQ-022 On start_valid in IDLE, SHALL clear accepted count, written count, and overflow, and latch relu_en/expected_count.
REQ-023 start_valid outside IDLE SHALL be ignored.
REQ-024 RUN: push {in_addr, processed in_data} into FIFO on in_valid when FIFO not full or a pop occurs the same cycle; each push increments accepted count.
REQ-025 RUN->DRAIN in the cycle the accepted count reaches expected_count; further in_valid SHALL be ignored.
REQ-026 DRAIN->DONE when written count equals expected_count; DONE->IDLE after one cycle, with done=1 only in DONE.
REQ-027 in_valid while FIFO full with no same-cycle pop SHALL drop the vector, not count it, and set overflow=1 (held until next accepted start).
REQ-028 An overflowing job SHALL not complete; only reset or a later start (after reset) recovers it.
REQ-029 in_valid in IDLE or DONE SHALL be ignored without setting overflow.
REQ-030 ReLU (relu_en latched 1): each lane with bit 31 set SHALL become 0; other lanes pass unchanged; relu_en=0 passes all lanes unchanged.
REQ-031 FIFO head SHALL drive buf_wr_addr/buf_wr_data, with buf_wr_en=!empty, registered; minimum latency in_valid->buf_wr_en is 1 cycle.
REQ-032 A write transfers when buf_wr_en&buf_wr_ready; addr/data SHALL stay stable while buf_wr_en=1 and buf_wr_ready=0.
REQ-033 Each transfer pops the FIFO and increments written count; write order SHALL equal arrival order.
REQ-034 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished with an extra pointer bit.
REQ-035 in_ready SHALL equal !full.

Reset
REQ-036 On rstn low, regardless of state: FSM=IDLE, FIFO empty, counters 0, buf_wr_en=0, buf_wr_addr=0, buf_wr_data=0, busy=0, overflow=0, done=0, in_ready=1.
REQ-037 Reset mid-job SHALL discard all FIFO contents without issuing further writes.

Verification
REQ-038 start, expected_count=3, relu_en=0; 3 in_valid cycles addr 5,6,7, buf_wr_ready=1 -> writes to 5,6,7 each 1 cycle after input, then done pulse once, busy low.
REQ-039 relu_en=1, lanes 0xFFFFFFFF, 0x00000005, 0x80000000 -> written lanes 0, 5, 0.
REQ-040 buf_wr_ready=0 for 10 cycles, 6 inputs with DEPTH=4 -> first 4 stored, in_ready low, overflow=1, 2 dropped, no done.
REQ-041 buf_wr_ready toggling 1/0 while FIFO full and in_valid each cycle -> push on pop cycles only, stable addr/data while stalled, order preserved.
REQ-042 start with expected_count=0 -> done 1 cycle later, no writes.
REQ-043 rstn low while FIFO holds 3 entries -> buf_wr_en 0 immediately, all outputs at reset values, new start works normally.
